apb_master: RTL and testbench

APB requester that converts single-beat register commands from a local controller (test sequencer, CPU bridge or config loader) into APB3 transfers. It drives the APB bus toward the image-filter register slave, which holds the CSC, ICSC, filter coefficients and bypass controls. Each transfer returns a one-cycle response pulse carrying read data and an error flag. A watchdog aborts any access the completer does not finish in time.

---
 rtl/apb_master.sv | 146 ++++++++++++++
 tb/tb_apb_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Brief    : Single-beat command to APB3 requester with an ACCESS-phase watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0] o_PADDR,
    output logic                  o_PSEL,
    output logic                  o_PENABLE,
    output logic                  o_PWRITE,
    output logic [DATA_WIDTH-1:0] o_PWDATA,
    input  logic                  i_PREADY,
    input  logic [DATA_WIDTH-1:0] i_PRDATA
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_accept;
    logic                    w_done;
    logic                    w_abort;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;

    assign w_accept = (r_state == S_IDLE) && i_cmd_valid;

    // PREADY is only looked at in ACCESS; it takes priority over the watchdog.
    always_comb begin
        w_next_state = r_state;
        w_done       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_next_state = S_SETUP;
                end
            end
            S_SETUP: begin
                w_next_state = S_ACCESS;
            end
            S_ACCESS: begin
                if (i_PREADY) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_abort      = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next_state;
            r_psel    <= (w_next_state != S_IDLE);
            r_penable <= (w_next_state == S_ACCESS);
            if (w_accept) begin
                r_cnt <= '0;
            end else if ((r_state == S_ACCESS) && !w_done && !w_abort) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    // Bus address/direction/data are only refreshed on command accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
        end else if (w_accept) begin
            r_paddr  <= i_cmd_addr;
            r_pwrite <= i_cmd_write;
            r_pwdata <= i_cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_done | w_abort;
            if (w_done) begin
                r_rsp_rdata <= r_pwrite ? '0 : i_PRDATA;
                r_rsp_err   <= 1'b0;
            end else if (w_abort) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_PSEL      = r_psel;
    assign o_PENABLE   = r_penable;
    assign o_PWRITE    = r_pwrite;
    assign o_PADDR     = r_paddr;
    assign o_PWDATA    = r_pwdata;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master
// Brief    : Randomized self-checking bench for apb_master with a memory completer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic        i_cmd_write = 1'b0;
    logic [9:0]  i_cmd_addr = '0;
    logic [31:0] i_cmd_wdata = '0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [9:0]  o_PADDR;
    logic        o_PSEL;
    logic        o_PENABLE;
    logic        o_PWRITE;
    logic [31:0] o_PWDATA;
    logic        i_PREADY = 1'b0;
    logic [31:0] i_PRDATA = '0;

    apb_master #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_write(i_cmd_write), .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_PADDR(o_PADDR), .o_PSEL(o_PSEL), .o_PENABLE(o_PENABLE),
        .o_PWRITE(o_PWRITE), .o_PWDATA(o_PWDATA),
        .i_PREADY(i_PREADY), .i_PRDATA(i_PRDATA)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Completer: storage, per-transfer wait-state count (<0 = never ready), stale PREADY outside ACCESS.
    logic [31:0] smem    [1024];
    logic [31:0] ref_mem [1024];
    int          slv_wait  = 0;
    bit          slv_stale = 1'b0;
    int          acc_cnt   = 0;

    always @(negedge clk) begin
        if (o_PSEL && o_PENABLE) begin
            if (slv_wait >= 0 && acc_cnt == slv_wait) begin
                i_PREADY = 1'b1;
                if (o_PWRITE) smem[o_PADDR] = o_PWDATA;
                i_PRDATA = o_PWRITE ? $urandom : smem[o_PADDR];
            end else begin
                i_PREADY = 1'b0;
                i_PRDATA = $urandom;
            end
            acc_cnt++;
        end else begin
            acc_cnt  = 0;
            i_PREADY = slv_stale;
            i_PRDATA = $urandom;
        end
    end

    // Observations of the last transfer driven by run_cmd.
    int          obs_cyc;
    int          obs_acc;
    logic [31:0] obs_rd;
    logic        obs_err;
    bit          obs_setup_ok;
    bit          obs_bus_ok;
    bit          obs_rdy_ok;

    // Expected response cycle from the wait-state count.
    function automatic int exp_cyc(input int w);
        return (w >= 0 && w < TIMEOUT) ? 3 + w : 2 + TIMEOUT;
    endfunction

    function automatic int exp_acc(input int w);
        return (w >= 0 && w < TIMEOUT) ? w + 1 : TIMEOUT;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where rsp_valid is seen.
    task automatic run_cmd(input logic wr, input logic [9:0] a, input logic [31:0] d,
                           input int w, input bit junk);
        slv_wait    = w;
        i_cmd_valid = 1'b1;
        i_cmd_write = wr;
        i_cmd_addr  = a;
        i_cmd_wdata = d;
        obs_rdy_ok  = (o_cmd_ready === 1'b1);
        obs_cyc = 0; obs_acc = 0; obs_setup_ok = 1'b0; obs_bus_ok = 1'b1;
        obs_rd = 'x; obs_err = 1'bx;
        @(posedge clk);
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (junk) begin
                i_cmd_addr  = 10'($urandom);
                i_cmd_write = 1'($urandom);
                i_cmd_wdata = $urandom;
            end else begin
                i_cmd_valid = 1'b0;
            end
            if (n == 1) obs_setup_ok = (o_PSEL === 1'b1 && o_PENABLE === 1'b0);
            if (o_PSEL === 1'b1 && o_PENABLE === 1'b1) obs_acc++;
            if (o_PADDR !== a || o_PWRITE !== wr || (wr && o_PWDATA !== d)) obs_bus_ok = 1'b0;
            if (o_rsp_valid === 1'b1) begin
                obs_cyc = n;
                obs_rd  = o_rsp_rdata;
                obs_err = o_rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", o_cmd_ready); end
        total++; if ({o_PSEL, o_PENABLE, o_PWRITE} !== 3'b000) begin bad++; $display("FAIL reset_ctrl got=%b want=000", {o_PSEL, o_PENABLE, o_PWRITE}); end
        total++; if (o_PADDR !== 10'd0 || o_PWDATA !== 32'd0) begin bad++; $display("FAIL reset_bus got=%h/%h want=0/0", o_PADDR, o_PWDATA); end
        total++; if ({o_rsp_valid, o_rsp_err} !== 2'b00 || o_rsp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rsp got=%b%b/%h want=00/0", o_rsp_valid, o_rsp_err, o_rsp_rdata); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        slv_stale = 1'b0;
        run_cmd(1'b1, 10'h000, 32'h1234_5678, 1, 1'b0);
        ref_mem[10'h000] = 32'h1234_5678;
        total++; if (!obs_rdy_ok || !obs_setup_ok) begin bad++; $display("FAIL wr_setup got=rdy%0b/setup%0b want=1/1", obs_rdy_ok, obs_setup_ok); end
        total++; if (obs_cyc !== 4 || obs_acc !== 2) begin bad++; $display("FAIL wr_timing got=cyc%0d/acc%0d want=4/2", obs_cyc, obs_acc); end
        total++; if (obs_err !== 1'b0 || obs_rd !== 32'd0) begin bad++; $display("FAIL wr_rsp got=%b/%h want=0/0", obs_err, obs_rd); end
        @(negedge clk);
        total++; if (o_rsp_valid !== 1'b0 || o_rsp_rdata !== 32'd0) begin bad++; $display("FAIL rsp_pulse got=%b/%h want=0/0", o_rsp_valid, o_rsp_rdata); end
        run_cmd(1'b1, 10'h070, 32'h0000_000F, 1, 1'b0);
        ref_mem[10'h070] = 32'h0000_000F;
        run_cmd(1'b0, 10'h070, 32'hDEAD_BEEF, 1, 1'b0);
        i_cmd_valid = 1'b0;
        total++; if (obs_cyc !== 4 || obs_err !== 1'b0) begin bad++; $display("FAIL rd70_rsp got=cyc%0d/err%b want=4/0", obs_cyc, obs_err); end
        total++; if (obs_rd !== ref_mem[10'h070]) begin bad++; $display("FAIL rd70_data got=%h want=%h", obs_rd, ref_mem[10'h070]); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        run_cmd(1'b0, 10'h010, 32'h0, -1, 1'b0);
        total++; if (obs_cyc !== 2 + TIMEOUT || obs_acc !== TIMEOUT) begin bad++; $display("FAIL to_timing got=cyc%0d/acc%0d want=%0d/%0d", obs_cyc, obs_acc, 2 + TIMEOUT, TIMEOUT); end
        total++; if (obs_err !== 1'b1 || obs_rd !== 32'd0) begin bad++; $display("FAIL to_rsp got=%b/%h want=1/0", obs_err, obs_rd); end
        run_cmd(1'b0, 10'h070, 32'h0, 0, 1'b0);
        i_cmd_valid = 1'b0;
        total++; if (!obs_rdy_ok || obs_cyc !== 3 || obs_rd !== ref_mem[10'h070] || obs_err !== 1'b0) begin bad++; $display("FAIL to_next got=rdy%0b/cyc%0d/%h want=1/3/%h", obs_rdy_ok, obs_cyc, obs_rd, ref_mem[10'h070]); end
        @(negedge clk);
        smem[10'h010] = 32'hA5A5_A5A5; ref_mem[10'h010] = 32'hA5A5_A5A5;
        run_cmd(1'b0, 10'h010, 32'h0, TIMEOUT - 1, 1'b0);
        i_cmd_valid = 1'b0;
        total++; if (obs_cyc !== exp_cyc(TIMEOUT - 1) || obs_err !== 1'b0 || obs_rd !== 32'hA5A5_A5A5) begin bad++; $display("FAIL last_ready got=cyc%0d/err%b/%h want=%0d/0/a5a5a5a5", obs_cyc, obs_err, obs_rd, exp_cyc(TIMEOUT - 1)); end
        @(negedge clk);
    endtask

    task automatic test_hold_valid();
        int          w;
        logic [9:0]  a;
        logic [31:0] d;
        bit          extra;
        w = $urandom_range(0, 3); a = 10'($urandom); d = $urandom;
        slv_stale = 1'b1;
        run_cmd(1'b1, a, d, w, 1'b1);
        i_cmd_valid = 1'b0;
        ref_mem[a] = d;
        total++; if (!obs_bus_ok) begin bad++; $display("FAIL hold_bus got=unstable want=paddr %h stable", a); end
        total++; if (obs_cyc !== exp_cyc(w) || obs_acc !== exp_acc(w)) begin bad++; $display("FAIL hold_timing got=cyc%0d/acc%0d want=%0d/%0d", obs_cyc, obs_acc, exp_cyc(w), exp_acc(w)); end
        extra = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (o_PSEL !== 1'b0) extra = 1'b1;
        end
        total++; if (extra) begin bad++; $display("FAIL hold_queued got=second transfer want=none"); end
        slv_stale = 1'b0;
    endtask

    task automatic test_random();
        int          w;
        logic        wr;
        logic [9:0]  a;
        logic [31:0] d, exp_rd;
        logic        exp_err;
        for (int k = 0; k < 40; k++) begin
            wr = 1'($urandom); a = 10'($urandom_range(0, 15)); d = $urandom;
            w  = ($urandom_range(0, 4) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 3) : $urandom_range(0, 3);
            slv_stale = 1'($urandom);
            exp_err = !(w < TIMEOUT);
            exp_rd  = (wr || exp_err) ? 32'd0 : ref_mem[a];
            run_cmd(wr, a, d, w, 1'b0);
            if (wr && !exp_err) ref_mem[a] = d;
            total++;
            if (!obs_rdy_ok || !obs_setup_ok || !obs_bus_ok || obs_cyc !== exp_cyc(w) ||
                obs_acc !== exp_acc(w) || obs_rd !== exp_rd || obs_err !== exp_err) begin
                bad++;
                $display("FAIL rand_%0d got=rdy%0b/su%0b/bus%0b/cyc%0d/acc%0d/%h/err%b want=1/1/1/%0d/%0d/%h/%b",
                         k, obs_rdy_ok, obs_setup_ok, obs_bus_ok, obs_cyc, obs_acc, obs_rd, obs_err,
                         exp_cyc(w), exp_acc(w), exp_rd, exp_err);
            end
            if ($urandom_range(0, 1) == 0) begin
                i_cmd_valid = 1'b0;
                @(negedge clk);
                total++; if (o_rsp_valid !== 1'b0 || o_rsp_rdata !== exp_rd || o_rsp_err !== exp_err) begin bad++; $display("FAIL rand_hold_%0d got=%b/%h/%b want=0/%h/%b", k, o_rsp_valid, o_rsp_rdata, o_rsp_err, exp_rd, exp_err); end
            end
        end
        i_cmd_valid = 1'b0;
        slv_stale = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen;
        slv_wait = -1;
        i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 10'h020; i_cmd_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk); i_cmd_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rstn = 1'b0;
        #1;
        total++; if ({o_PSEL, o_PENABLE, o_rsp_valid} !== 3'b000 || o_cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_mid got=%b rdy%b want=000 rdy1", {o_PSEL, o_PENABLE, o_rsp_valid}, o_cmd_ready); end
        total++; if (o_PADDR !== 10'd0 || o_PWRITE !== 1'b0 || o_PWDATA !== 32'd0) begin bad++; $display("FAIL rst_mid_bus got=%h/%b/%h want=0/0/0", o_PADDR, o_PWRITE, o_PWDATA); end
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (o_rsp_valid !== 1'b0 || o_PSEL !== 1'b0 || o_cmd_ready !== 1'b1) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL rst_after got=activity want=idle"); end
        run_cmd(1'b0, 10'h020, 32'h0, 1, 1'b0);
        i_cmd_valid = 1'b0;
        total++; if (obs_cyc !== 4 || obs_rd !== ref_mem[10'h020]) begin bad++; $display("FAIL rst_nowrite got=cyc%0d/%h want=4/%h", obs_cyc, obs_rd, ref_mem[10'h020]); end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            smem[i]    = $urandom;
            ref_mem[i] = smem[i];
        end
        test_reset();
        test_write_read();
        test_timeout();
        test_hold_valid();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
